// File: rtl/cs_y_collector_pkg.sv
// Shared CS constants and the result record carried through the collector FIFO.
package cs_pkg;

  localparam int unsigned CS_Y_W    = 10;
  localparam int unsigned CS_SEQ_W  = 8;
  localparam int unsigned CS_WINDOW = 9;

  typedef struct packed {
    logic [CS_SEQ_W-1:0] seq;
    logic [CS_Y_W-1:0]   y;
  } cs_result_t;

endpackage

// File: rtl/cs_y_collector_if.sv
// Result stream handshake: producer drives valid/data/seq, consumer drives ready.
interface cs_y_collector_if;
  import cs_pkg::*;

  logic                out_valid;
  logic                out_ready;
  logic [CS_Y_W-1:0]   out_data;
  logic [CS_SEQ_W-1:0] out_seq;

  modport master (
    output out_valid,
    output out_data,
    output out_seq,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_seq,
    output out_ready
  );

endinterface

// File: rtl/cs_y_collector_fifo.sv
// Synchronous FIFO of cs_result_t with explicit occupancy; clear beats push/pop,
// and a push into a full FIFO succeeds only when a pop happens on the same edge.
module cs_fifo
  import cs_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned FILL_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  cs_result_t        wdata,
  input  logic              pop,
  output cs_result_t        rdata,
  output logic              full,
  output logic              empty,
  output logic [FILL_W-1:0] fill
);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  cs_result_t        mem_q [DEPTH];
  cs_result_t        mem_d [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign full  = (fill_q == FILL_W'(DEPTH));
  assign empty = (fill_q == '0);
  assign fill  = fill_q;
  // Head reads as zero while empty so reset and drained states look identical.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // Qualify requests: clear wins, pop needs data, push needs room or a same-edge pop.
  always_comb begin
    do_pop  = pop && !empty && !clear;
    do_push = push && !clear && (!full || do_pop);
  end

  // Next pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   fill_d = fill_q + FILL_W'(1);
        2'b01:   fill_d = fill_q - FILL_W'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  // Storage write: only the slot under the write pointer changes.
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = wdata;
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cs_y_collector.sv
// Collects CS Y results: drops warm-up captures after reset, tags kept results
// with a sequence number, buffers them and flags drops caused by backpressure.
module cs_y_collector
  import cs_pkg::*;
#(
  parameter int unsigned WARMUP = CS_WINDOW,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CS_Y_W-1:0]     y_in,
  input  logic                  clear,
  cs_y_collector_if.master      out_if,
  output logic [$clog2(DEPTH):0] fill,
  output logic                  overflow
);

  localparam int unsigned WARM_W = (WARMUP == 0) ? 1 : $clog2(WARMUP + 1);

  logic [WARM_W-1:0]   warm_q, warm_d;
  logic [CS_SEQ_W-1:0] seq_q, seq_d;
  logic                overflow_q, overflow_d;
  logic                kept;
  logic                pop_req;
  logic                fifo_full;
  logic                fifo_empty;
  cs_result_t          wr_entry;
  cs_result_t          head;

  // A capture is kept once the saturating warm-up counter has reached WARMUP.
  assign kept    = (warm_q == WARM_W'(WARMUP));
  assign pop_req = out_if.out_ready && !fifo_empty && !clear;

  // Warm-up and sequence counters; clear does not touch either.
  always_comb begin
    warm_d = warm_q;
    seq_d  = seq_q;
    if (!kept) warm_d = warm_q + WARM_W'(1);
    if (kept)  seq_d  = seq_q + CS_SEQ_W'(1);
  end

  // Sticky overflow: set by a kept capture hitting a full FIFO with no pop.
  always_comb begin
    overflow_d = overflow_q;
    if (clear)                               overflow_d = 1'b0;
    else if (kept && fifo_full && !pop_req)  overflow_d = 1'b1;
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warm_q     <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      warm_q     <= warm_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry offered to the FIFO: current sequence tag with the captured Y.
  always_comb begin
    wr_entry     = '0;
    wr_entry.seq = seq_q;
    wr_entry.y   = y_in;
  end

  cs_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clear (clear),
    .push  (kept),
    .wdata (wr_entry),
    .pop   (out_if.out_ready),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

  assign overflow         = overflow_q;
  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = head.y;
  assign out_if.out_seq   = head.seq;

endmodule

// File: tb/tb_cs_y_collector.sv
// Bench for cs_y_collector: directed vector table, random traffic against a
// queue-based model, sequence wrap, and asynchronous reset mid-stream.
module tb_cs_y_collector;

  localparam int WARMUP = 9;
  localparam int DEPTH  = 8;

  logic       clk;
  logic       rst_n;
  logic [9:0] yv;
  logic       clr;
  logic [3:0] fill;
  logic       overflow;

  cs_y_collector_if bus ();

  cs_y_collector #(
    .WARMUP (WARMUP),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .y_in     (yv),
    .clear    (clr),
    .out_if   (bus.master),
    .fill     (fill),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: a queue of {seq, y} plus plain integer counters.
  typedef struct { int seq; int y; } ent_t;
  ent_t mq[$];
  int   mwarm;
  int   mseq;
  bit   movf;

  function automatic void model_reset();
    mq.delete();
    mwarm = 0;
    mseq  = 0;
    movf  = 1'b0;
  endfunction

  function automatic void model_edge();
    bit   kept;
    bit   do_pop;
    ent_t e;
    kept   = (mwarm >= WARMUP);
    do_pop = (mq.size() > 0) && bus.out_ready && !clr;
    if (!kept) mwarm++;
    if (clr) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (kept) begin
        if (mq.size() < DEPTH) begin
          e.seq = mseq;
          e.y   = int'(yv);
          mq.push_back(e);
        end else begin
          movf = 1'b1;
        end
      end
    end
    if (kept) mseq = (mseq + 1) % 256;
  endfunction

  task automatic compare_model();
    chk("m_valid", bus.out_valid, mq.size() > 0);
    chk("m_fill", fill, mq.size());
    chk("m_ovf", overflow, movf);
    if (mq.size() > 0) begin
      chk("m_data", bus.out_data, mq[0].y);
      chk("m_seq", bus.out_seq, mq[0].seq);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  typedef struct {
    bit clr;
    bit rdy;
    int y;
    bit ev;
    int ed;
    int es;
    int ef;
    bit eo;
  } vec_t;

  function automatic vec_t mk(bit c, bit r, int y, bit v, int d, int s, int f, bit o);
    vec_t t;
    t.clr = c; t.rdy = r; t.y = y; t.ev = v; t.ed = d; t.es = s; t.ef = f; t.eo = o;
    return t;
  endfunction

  vec_t tbl[24];

  int  prev_seq;
  bit  prev_valid;
  int  wraps;

  initial begin
    // Directed vectors: expected outputs after the edge that applies each row.
    for (int i = 0; i < 9; i++) tbl[i] = mk(0, 1, 225, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 225, 1, 225, 0, 1, 0);
    tbl[10] = mk(0, 1, 225, 1, 225, 1, 1, 0);
    tbl[11] = mk(0, 1, 225, 1, 225, 2, 1, 0);
    tbl[12] = mk(0, 1, 300, 1, 300, 3, 1, 0);
    for (int j = 0; j < 7; j++) tbl[13 + j] = mk(0, 0, 301 + j, 1, 300, 3, 2 + j, 0);
    tbl[20] = mk(0, 0, 400, 1, 300, 3, 8, 1);   // full, no pop: dropped
    tbl[21] = mk(0, 1, 401, 1, 301, 4, 8, 1);   // full with pop: fill holds
    tbl[22] = mk(1, 1, 402, 0, 0, 0, 0, 0);     // clear wins, capture lost
    tbl[23] = mk(0, 0, 403, 1, 403, 14, 1, 0);  // seq continues past the gap

    rst_n = 1'b0;
    clr = 1'b0;
    bus.out_ready = 1'b1;
    yv = '0;
    model_reset();
    #2;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_seq", bus.out_seq, 0);
    chk("rst_fill", fill, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      clr = tbl[i].clr;
      bus.out_ready = tbl[i].rdy;
      yv = 10'(tbl[i].y);
      step();
      chk($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_fill", i), fill, tbl[i].ef);
      chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].eo);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), bus.out_data, tbl[i].ed);
        chk($sformatf("tbl%0d_seq", i), bus.out_seq, tbl[i].es);
      end
    end

    // Random traffic: a heavy-backpressure phase then a light one.
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 63) == 0);
      if (i < 200) bus.out_ready = ($urandom_range(0, 3) == 0);
      else         bus.out_ready = ($urandom_range(0, 3) != 0);
      yv = 10'($urandom_range(0, 1023));
      step();
    end

    // Sequence wrap with a consumer that is always ready.
    clr = 1'b0;
    bus.out_ready = 1'b1;
    prev_valid = 1'b0;
    prev_seq = 0;
    wraps = 0;
    for (int i = 0; i < 300; i++) begin
      yv = 10'($urandom_range(0, 1023));
      step();
      if (i > 0) chk("wrap_valid", bus.out_valid, 1);
      if (prev_valid && bus.out_valid && prev_seq == 255 && bus.out_seq == 0) wraps++;
      prev_valid = bus.out_valid;
      prev_seq = int'(bus.out_seq);
    end
    chk("wrap_seen", wraps >= 1, 1);

    // Reset mid-stream with three entries buffered.
    clr = 1'b1;
    step();
    clr = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      yv = 10'(i + 7);
      step();
    end
    chk("pre_rst_fill", fill, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", bus.out_valid, 0);
    chk("async_data", bus.out_data, 0);
    chk("async_seq", bus.out_seq, 0);
    chk("async_fill", fill, 0);
    chk("async_ovf", overflow, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      yv = 10'(50 + i);
      step();
      chk("rewarm_valid", bus.out_valid, 0);
    end
    yv = 10'd77;
    step();
    chk("rewarm_first_valid", bus.out_valid, 1);
    chk("rewarm_first_seq", bus.out_seq, 0);
    chk("rewarm_first_data", bus.out_data, 77);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
